uart_frame_parser: RTL and testbench

Byte-stream deframer directly downstream of the UART receiver. Consumes the receiver's byte/strobe pair (RX_DATA/RX_RECV), hunts for a sync byte, and collects a length-prefixed, checksummed payload into an internal buffer. Releases the payload through a valid/ready byte stream only after the checksum passes. Reports malformed, corrupted and stalled frames as one-cycle error pulses.

---
 rtl/uart_frame_parser.sv | 152 +++++++++++++++
 tb/tb_uart_frame_parser.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Deframer behind the UART receiver: hunts SYNC_BYTE, buffers a length-prefixed
// checksummed payload, then replays it on a valid/ready byte stream.
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_recv,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] frame_len,
    output logic       err_csum,
    output logic       err_len,
    output logic       err_timeout,
    output logic       overrun
);

    localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       len, sum, wr_ptr, rd_ptr;
    logic [7:0]       csum_chk;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       mem [MAX_LEN];
    logic             in_frame, tmo_hit, xfer;
    logic             err_csum_nxt, err_len_nxt, err_tmo_nxt, overrun_nxt;

    assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
    // A byte landing on the expiry cycle takes priority over the timeout.
    assign tmo_hit  = in_frame && !rx_recv && (tmo_cnt == TMO_LAST);
    assign csum_chk = sum + rx_data;

    assign out_valid = (state == ST_DRAIN);
    assign out_data  = out_valid ? mem[rd_ptr[IDX_W-1:0]] : 8'h00;
    assign out_last  = out_valid && (rd_ptr == frame_len - 8'd1);
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_HUNT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        err_csum_nxt = 1'b0;
        err_len_nxt  = 1'b0;
        err_tmo_nxt  = 1'b0;
        overrun_nxt  = 1'b0;
        case (state)
            ST_HUNT:
                if (rx_recv && rx_data == SYNC_BYTE) state_nxt = ST_LEN;
            ST_LEN:
                if (rx_recv) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        err_len_nxt = 1'b1;
                        state_nxt   = ST_HUNT;
                    end else begin
                        state_nxt = ST_PAYLOAD;
                    end
                end
            ST_PAYLOAD:
                if (rx_recv && wr_ptr == len - 8'd1) state_nxt = ST_CSUM;
            ST_CSUM:
                if (rx_recv) begin
                    if (csum_chk == 8'd0) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        err_csum_nxt = 1'b1;
                        state_nxt    = ST_HUNT;
                    end
                end
            ST_DRAIN: begin
                overrun_nxt = rx_recv;
                if (xfer && out_last) state_nxt = ST_HUNT;
            end
            default: state_nxt = ST_HUNT;
        endcase
        if (tmo_hit) begin
            err_tmo_nxt = 1'b1;
            state_nxt   = ST_HUNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            err_csum    <= err_csum_nxt;
            err_len     <= err_len_nxt;
            err_timeout <= err_tmo_nxt;
            overrun     <= overrun_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= 8'd0;
            sum       <= 8'd0;
            wr_ptr    <= 8'd0;
            rd_ptr    <= 8'd0;
            frame_len <= 8'd0;
        end else begin
            if (state == ST_LEN && rx_recv) begin
                len    <= rx_data;
                sum    <= rx_data;
                wr_ptr <= 8'd0;
            end
            if (state == ST_PAYLOAD && rx_recv) begin
                sum    <= csum_chk;
                wr_ptr <= wr_ptr + 8'd1;
            end
            if (state == ST_CSUM && rx_recv && csum_chk == 8'd0) begin
                frame_len <= len;
                rd_ptr    <= 8'd0;
            end
            if (xfer) rd_ptr <= rd_ptr + 8'd1;
        end
    end

    // Only runs while a frame is open; HUNT/DRAIN park it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    tmo_cnt <= '0;
        else if (rx_recv || !in_frame) tmo_cnt <= '0;
        else if (tmo_cnt != TMO_MAX)   tmo_cnt <= tmo_cnt + TMO_ONE;
    end

    always_ff @(posedge clk) begin
        if (state == ST_PAYLOAD && rx_recv) mem[wr_ptr[IDX_W-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: table of whole frames plus hand-written
// timeout, backpressure/overrun and reset sequences.
module tb_uart_frame_parser;

    localparam int T = 20000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_recv;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] frame_len;
    logic       err_csum, err_len, err_timeout, overrun;

    int nvec = 0;
    int nmis = 0;

    uart_frame_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_recv(rx_recv),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_len(frame_len), .err_csum(err_csum),
        .err_len(err_len), .err_timeout(err_timeout), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // kind: 0 no output, 1 good frame, 2 length error, 3 checksum error
    typedef struct packed {
        logic [3:0]  nbytes;
        logic [63:0] bytes;
        logic [1:0]  kind;
        logic [7:0]  exp_len;
        logic [31:0] pay;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_recv = 1'b1;
        tick();
        rx_recv = 1'b0;
    endtask

    // Called in the cycle after the checksum strobe, with out_ready high.
    task automatic drain_check(input int n, input logic [31:0] pay);
        for (int i = 0; i < n; i++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_data", 32'(out_data), 32'(pay[31-8*i -: 8]));
            chk("drain_last", 32'(out_last), 32'(i == n - 1));
            tick();
        end
        chk("drain_done", 32'(out_valid), 32'd0);
    endtask

    task automatic send_good_a();
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
    endtask

    initial begin
        int ov_cnt;
        vecs[0] = '{4'd6, 64'hA503112233970000, 2'd1, 8'd3, 32'h11223300};
        vecs[1] = '{4'd6, 64'hA503112233980000, 2'd3, 8'd0, 32'h0};
        vecs[2] = '{4'd5, 64'hA5021020CE000000, 2'd1, 8'd2, 32'h10200000};
        vecs[3] = '{4'd2, 64'hA500000000000000, 2'd2, 8'd0, 32'h0};
        vecs[4] = '{4'd2, 64'hA511000000000000, 2'd2, 8'd0, 32'h0};
        vecs[5] = '{4'd2, 64'h1122000000000000, 2'd0, 8'd0, 32'h0};
        vecs[6] = '{4'd4, 64'hA501A55A00000000, 2'd1, 8'd1, 32'hA5000000};

        rst_n = 1'b0; rx_data = 8'h00; rx_recv = 1'b0; out_ready = 1'b1;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_flen", 32'(frame_len), 32'd0);
        chk("rst_errs", {28'd0, err_csum, err_len, err_timeout, overrun}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            out_ready = 1'b1;
            for (int i = 0; i < int'(vecs[v].nbytes); i++) send(vecs[v].bytes[63-8*i -: 8]);
            case (vecs[v].kind)
                2'd1: begin
                    chk("good_errs", {29'd0, err_csum, err_len, err_timeout}, 32'd0);
                    chk("good_flen", 32'(frame_len), 32'(vecs[v].exp_len));
                    drain_check(int'(vecs[v].exp_len), vecs[v].pay);
                end
                2'd2: begin
                    chk("len_err", 32'(err_len), 32'd1);
                    chk("len_valid", 32'(out_valid), 32'd0);
                    tick();
                    chk("len_err_clear", 32'(err_len), 32'd0);
                end
                2'd3: begin
                    chk("csum_err", 32'(err_csum), 32'd1);
                    chk("csum_valid", 32'(out_valid), 32'd0);
                    tick();
                    chk("csum_err_clear", 32'(err_csum), 32'd0);
                    chk("csum_valid2", 32'(out_valid), 32'd0);
                end
                default: begin
                    chk("nosync_valid", 32'(out_valid), 32'd0);
                    chk("nosync_errs", {30'd0, err_csum, err_len}, 32'd0);
                end
            endcase
            tick(); tick();
        end

        // Inter-byte timeout: pulse lands T cycles after the last strobe.
        send(8'hA5); send(8'h02); send(8'h11);
        for (int i = 0; i < T - 1; i++) tick();
        chk("tmo_early", 32'(err_timeout), 32'd0);
        tick();
        chk("tmo_pulse", 32'(err_timeout), 32'd1);
        tick();
        chk("tmo_clear", 32'(err_timeout), 32'd0);
        send_good_a();
        drain_check(3, 32'h11223300);

        // Byte on the expiry cycle wins and the frame completes.
        send(8'hA5); send(8'h02); send(8'h11);
        for (int i = 0; i < T - 1; i++) tick();
        send(8'h22);
        chk("tmo_byte_wins", 32'(err_timeout), 32'd0);
        send(8'hCB);
        chk("tmo_byte_valid", 32'(err_timeout), 32'd0);
        drain_check(2, 32'h11220000);

        // Backpressure with overruns during DRAIN.
        out_ready = 1'b0;
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'hCE);
        ov_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'h10);
            chk("hold_last", 32'(out_last), 32'd0);
            if (overrun) ov_cnt++;
            rx_data = (k == 1) ? 8'hA5 : 8'h33;
            rx_recv = (k == 1 || k == 3 || k == 5);
            tick();
        end
        rx_recv = 1'b0;
        chk("overrun_count", 32'(ov_cnt), 32'd3);
        out_ready = 1'b1;
        drain_check(2, 32'h10200000);

        // Reset mid-payload.
        send(8'hA5); send(8'h03); send(8'h11);
        rst_n = 1'b0;
        #1;
        chk("rstp_valid", 32'(out_valid), 32'd0);
        chk("rstp_flen", 32'(frame_len), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_good_a();
        chk("rstp_flen2", 32'(frame_len), 32'd3);
        drain_check(3, 32'h11223300);

        // Reset mid-drain: the partial frame is lost.
        send_good_a();
        out_ready = 1'b1;
        chk("rstd_first", 32'(out_data), 32'h11);
        tick();
        out_ready = 1'b0;
        chk("rstd_second", 32'(out_data), 32'h22);
        rst_n = 1'b0;
        #1;
        chk("rstd_valid", 32'(out_valid), 32'd0);
        chk("rstd_data", 32'(out_data), 32'd0);
        chk("rstd_last", 32'(out_last), 32'd0);
        chk("rstd_flen", 32'(frame_len), 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("rstd_idle", 32'(out_valid), 32'd0);
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'hCE);
        chk("rstd_flen2", 32'(frame_len), 32'd2);
        drain_check(2, 32'h10200000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
